// File: rtl/vram_bram_target_if.sv
// VRAM access bus: sel/wr/mask/address/data request with a single-cycle ack.
interface vram_bram_target_if;
  logic        sel_i;
  logic        wr_i;
  logic [3:0]  mask_i;
  logic [23:0] address_i;
  logic [15:0] data_in_i;
  logic [15:0] data_out_o;
  logic        ack_o;
  logic        busy_o;
  logic        err_o;

  modport master (
    output sel_i, wr_i, mask_i, address_i, data_in_i,
    input  data_out_o, ack_o, busy_o, err_o
  );

  modport slave (
    input  sel_i, wr_i, mask_i, address_i, data_in_i,
    output data_out_o, ack_o, busy_o, err_o
  );
endinterface

// File: rtl/vram_bram_target.sv
// Block-RAM backed responder for the VRAM access bus, with programmable
// wait states, nibble write masks and sticky out-of-range detection.
module vram_bram_target #(
  parameter int unsigned DEPTH       = 4096,
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [15:0] OOR_DATA    = 16'hDEAD
) (
  input  logic                clk,
  input  logic                reset_n_i,
  vram_bram_target_if.slave   bus,
  output logic [1:0]          dbg_state_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned DW = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_MEM  = 2'd2,
    S_ACK  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            req_wr_q, req_wr_d;
  logic [3:0]      req_mask_q, req_mask_d;
  logic [23:0]     req_addr_q, req_addr_d;
  logic [DW-1:0]   req_data_q, req_data_d;
  logic            ack_q, ack_d;
  logic            busy_q, busy_d;
  logic            err_q, err_d;
  logic [DW-1:0]   dout_q, dout_d;

  logic [DW-1:0]   mem_q [DEPTH];
  logic [AW-1:0]   ram_idx_c;
  logic            in_range_c;
  logic [DW-1:0]   mask_bits_c;
  logic            ram_we_c;
  logic [DW-1:0]   ram_rd_c;

  // Full 24-bit compare so high addresses never alias onto the RAM.
  assign ram_idx_c   = req_addr_q[AW-1:0];
  assign in_range_c  = (req_addr_q < 24'(DEPTH));
  assign mask_bits_c = {{4{req_mask_q[3]}}, {4{req_mask_q[2]}},
                        {4{req_mask_q[1]}}, {4{req_mask_q[0]}}};
  assign ram_we_c    = (state_q == S_MEM) && req_wr_q && in_range_c;
  assign ram_rd_c    = mem_q[ram_idx_c];

  // RAM array: no reset, nibble-merged write.
  always_ff @(posedge clk) begin
    if (ram_we_c) begin
      mem_q[ram_idx_c] <= (mem_q[ram_idx_c] & ~mask_bits_c) | (req_data_q & mask_bits_c);
    end
  end

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      req_wr_q   <= 1'b0;
      req_mask_q <= 4'd0;
      req_addr_q <= 24'd0;
      req_data_q <= '0;
      ack_q      <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      dout_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_wr_q   <= req_wr_d;
      req_mask_q <= req_mask_d;
      req_addr_q <= req_addr_d;
      req_data_q <= req_data_d;
      ack_q      <= ack_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      dout_q     <= dout_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_wr_d   = req_wr_q;
    req_mask_d = req_mask_q;
    req_addr_d = req_addr_q;
    req_data_d = req_data_q;
    ack_d      = 1'b0;
    busy_d     = busy_q;
    err_d      = err_q;
    dout_d     = dout_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.sel_i) begin
          req_wr_d   = bus.wr_i;
          req_mask_d = bus.mask_i;
          req_addr_d = bus.address_i;
          req_data_d = bus.data_in_i;
          busy_d     = 1'b1;
          if (WAIT_STATES != 0) begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_STATES - 1);
          end else begin
            state_d = S_MEM;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_MEM;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_MEM: begin
        state_d = S_ACK;
        ack_d   = 1'b1;
        if (!in_range_c) begin
          err_d = 1'b1;
          if (!req_wr_q) begin
            dout_d = OOR_DATA;
          end
        end else if (!req_wr_q) begin
          dout_d = ram_rd_c;
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.data_out_o = dout_q;
  assign bus.ack_o      = ack_q;
  assign bus.busy_o     = busy_q;
  assign bus.err_o      = err_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_vram_bram_target.sv
// Bench for vram_bram_target: three instances (0, 3 and 2 wait states) checked
// every cycle against a transaction-level model plus directed literal checks.
module tb_vram_bram_target;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_cmp = 0;
  int n_err = 0;

  logic        sel_r  [3];
  logic        wr_r   [3];
  logic [3:0]  mask_r [3];
  logic [23:0] addr_r [3];
  logic [15:0] din_r  [3];
  logic [2:0]  ack_w, busy_w, err_w;
  logic [15:0] dout_w [3];
  logic [1:0]  dbg_w  [3];

  function automatic int ws_of(input int k);
    return (k == 0) ? 0 : (k == 1) ? 3 : 2;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned WS = (g == 0) ? 0 : (g == 1) ? 3 : 2;
    vram_bram_target_if bus ();
    assign bus.sel_i     = sel_r[g];
    assign bus.wr_i      = wr_r[g];
    assign bus.mask_i    = mask_r[g];
    assign bus.address_i = addr_r[g];
    assign bus.data_in_i = din_r[g];
    assign ack_w[g]      = bus.ack_o;
    assign busy_w[g]     = bus.busy_o;
    assign err_w[g]      = bus.err_o;
    assign dout_w[g]     = bus.data_out_o;
    vram_bram_target #(.DEPTH(4096), .WAIT_STATES(WS), .OOR_DATA(16'hDEAD)) u_dut (
      .clk         (clk),
      .reset_n_i   (rst_n),
      .bus         (bus),
      .dbg_state_o (dbg_w[g])
    );
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Transaction model: ph counts cycles since capture; effect lands when ack begins.
  int          ph     [3] = '{0, 0, 0};
  logic        q_wr   [3];
  logic [3:0]  q_mask [3];
  logic [23:0] q_addr [3];
  logic [15:0] q_data [3];
  logic [15:0] mdout  [3] = '{16'h0, 16'h0, 16'h0};
  logic        merr   [3] = '{1'b0, 1'b0, 1'b0};
  logic [15:0] mdl_mem [3][4096];

  task automatic apply(input int k);
    if (q_addr[k] < 24'd4096) begin
      if (q_wr[k]) begin
        for (int n = 0; n < 4; n++)
          if (q_mask[k][n]) mdl_mem[k][q_addr[k][11:0]][4*n +: 4] = q_data[k][4*n +: 4];
      end else begin
        mdout[k] = mdl_mem[k][q_addr[k][11:0]];
      end
    end else begin
      merr[k] = 1'b1;
      if (!q_wr[k]) mdout[k] = 16'hDEAD;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        ph[k] = 0; mdout[k] = 16'h0; merr[k] = 1'b0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (ph[k] == 0) begin
          if (sel_r[k]) begin
            q_wr[k] = wr_r[k]; q_mask[k] = mask_r[k];
            q_addr[k] = addr_r[k]; q_data[k] = din_r[k];
            ph[k] = 1;
          end
        end else if (ph[k] == ws_of(k) + 2) begin
          ph[k] = 0;
        end else begin
          ph[k]++;
          if (ph[k] == ws_of(k) + 2) apply(k);
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      int w;
      logic [1:0] st;
      w  = ws_of(k);
      st = (ph[k] == 0) ? 2'd0 : (ph[k] <= w) ? 2'd1 : (ph[k] == w + 1) ? 2'd2 : 2'd3;
      chk($sformatf("ack[%0d]", k),  32'(ack_w[k]),  32'(ph[k] == w + 2));
      chk($sformatf("busy[%0d]", k), 32'(busy_w[k]), 32'(ph[k] != 0));
      chk($sformatf("err[%0d]", k),  32'(err_w[k]),  32'(merr[k]));
      chk($sformatf("dout[%0d]", k), 32'(dout_w[k]), 32'(mdout[k]));
      chk($sformatf("state[%0d]", k), 32'(dbg_w[k]), 32'(st));
    end
  end

  task automatic txn(input int k, input logic w, input logic [3:0] m, input logic [23:0] a,
                     input logic [15:0] d, output int lat, output logic [15:0] rd);
    int t0;
    @(posedge clk); #1;
    sel_r[k] = 1'b1; wr_r[k] = w; mask_r[k] = m; addr_r[k] = a; din_r[k] = d;
    t0  = cyc;
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ack_w[k]) begin
        lat = cyc - t0;
        break;
      end
    end
    rd = dout_w[k];
    @(posedge clk); #1;
    sel_r[k] = 1'b0;
  endtask

  initial begin
    int lat;
    int nack;
    int t0;
    int acks [3];
    logic [15:0] rd;

    for (int k = 0; k < 3; k++) begin
      sel_r[k] = 1'b0; wr_r[k] = 1'b0; mask_r[k] = 4'h0; addr_r[k] = 24'h0; din_r[k] = 16'h0;
      for (int a = 0; a < 4096; a++) mdl_mem[k][a] = 16'h0;
    end
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset ack", 32'(ack_w[0]), 32'd0);
    chk("reset busy", 32'(busy_w[0]), 32'd0);
    chk("reset dout", 32'(dout_w[0]), 32'h0);
    chk("reset state", 32'(dbg_w[0]), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Basic write/read, no wait states.
    txn(0, 1'b1, 4'hF, 24'd5, 16'h0F3C, lat, rd);
    chk("wr latency", 32'(lat), 32'd2);
    txn(0, 1'b0, 4'hF, 24'd5, 16'h0, lat, rd);
    chk("rd latency", 32'(lat), 32'd2);
    chk("rd addr5", 32'(rd), 32'h0F3C);
    chk("err clean", 32'(err_w[0]), 32'd0);

    // Nibble masks.
    txn(0, 1'b1, 4'hF, 24'd7, 16'h1234, lat, rd);
    txn(0, 1'b1, 4'b0101, 24'd7, 16'hABCD, lat, rd);
    txn(0, 1'b0, 4'hF, 24'd7, 16'h0, lat, rd);
    chk("mask 0101", 32'(rd), 32'h1B3D);
    txn(0, 1'b1, 4'b0000, 24'd7, 16'hFFFF, lat, rd);
    chk("mask0 latency", 32'(lat), 32'd2);
    txn(0, 1'b0, 4'hF, 24'd7, 16'h0, lat, rd);
    chk("mask 0000", 32'(rd), 32'h1B3D);

    // Out of range and boundaries.
    txn(0, 1'b1, 4'hF, 24'd0, 16'h0A0A, lat, rd);
    txn(0, 1'b1, 4'hF, 24'd4095, 16'hBEEF, lat, rd);
    txn(0, 1'b0, 4'hF, 24'd4096, 16'h0, lat, rd);
    chk("oor read", 32'(rd), 32'hDEAD);
    chk("oor err", 32'(err_w[0]), 32'd1);
    txn(0, 1'b1, 4'hF, 24'h001000, 16'h5555, lat, rd);
    txn(0, 1'b0, 4'hF, 24'd0, 16'h0, lat, rd);
    chk("no alias addr0", 32'(rd), 32'h0A0A);
    chk("err sticky", 32'(err_w[0]), 32'd1);
    txn(0, 1'b0, 4'hF, 24'd4095, 16'h0, lat, rd);
    chk("rd 4095", 32'(rd), 32'hBEEF);
    txn(0, 1'b0, 4'hF, 24'hFFFFFF, 16'h0, lat, rd);
    chk("rd FFFFFF", 32'(rd), 32'hDEAD);

    // data_out hold across a write.
    txn(0, 1'b1, 4'hF, 24'd20, 16'h00AA, lat, rd);
    txn(0, 1'b0, 4'hF, 24'd20, 16'h0, lat, rd);
    chk("hold rd", 32'(rd), 32'h00AA);
    txn(0, 1'b1, 4'hF, 24'd21, 16'h7777, lat, rd);
    chk("hold at wr ack", 32'(rd), 32'h00AA);
    repeat (2) @(negedge clk);
    chk("hold after wr", 32'(dout_w[0]), 32'h00AA);

    // Three wait states, sel held high continuously.
    @(posedge clk); #1;
    sel_r[1] = 1'b1; wr_r[1] = 1'b1; mask_r[1] = 4'hF; addr_r[1] = 24'd3; din_r[1] = 16'h1111;
    t0 = cyc;
    nack = 0;
    acks = '{-1, -1, -1};
    for (int i = 0; i < 30 && nack < 3; i++) begin
      @(negedge clk);
      if (ack_w[1]) begin
        acks[nack] = cyc - t0;
        nack++;
      end
    end
    @(posedge clk); #1 sel_r[1] = 1'b0;
    chk("held ack1", 32'(acks[0]), 32'd5);
    chk("held ack2", 32'(acks[1]), 32'd11);
    chk("held ack3", 32'(acks[2]), 32'd17);

    // Reset during the WAIT of a write (two wait states).
    txn(2, 1'b1, 4'hF, 24'd9, 16'h0909, lat, rd);
    chk("ws2 latency", 32'(lat), 32'd4);
    @(posedge clk); #1;
    sel_r[2] = 1'b1; wr_r[2] = 1'b1; mask_r[2] = 4'hF; addr_r[2] = 24'd9; din_r[2] = 16'hFFFF;
    @(posedge clk); #1;
    rst_n = 1'b0;
    sel_r[2] = 1'b0;
    @(negedge clk);
    chk("abort ack", 32'(ack_w[2]), 32'd0);
    chk("abort busy", 32'(busy_w[2]), 32'd0);
    chk("abort state", 32'(dbg_w[2]), 32'd0);
    chk("abort err0", 32'(err_w[0]), 32'd0);
    chk("abort dout0", 32'(dout_w[0]), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("no late ack", 32'(ack_w[2]), 32'd0);
    txn(2, 1'b0, 4'hF, 24'd9, 16'h0, lat, rd);
    chk("aborted write", 32'(rd), 32'h0909);
    chk("ws2 rd latency", 32'(lat), 32'd4);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
